// File: rtl/ezp_encode.sv
// ezp_encode: EZPack packet encoder.
// Collects a command byte and a last-flagged payload stream, then frames them as
// START, CMD, LEN, payload, CHK, END in a packed vector with byte k at [8k+7:8k].
// Optional feature macro: EZP_ENCODE_CHK_EN.
//   Defined:   CHK is the XOR of CMD, LEN and every stored payload byte.
//   Undefined: CHK is 8'h00 and no accumulator exists.
module ezp_encode #(
    parameter logic [7:0] START_BYTE = 8'hAA,
    parameter logic [7:0] END_BYTE   = 8'h55,
    parameter int         MAX_PD_LEN = 32'd2,
    parameter int         MAX_PKTLEN = MAX_PD_LEN + 32'd5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_cmd,
    input  logic [7:0]              i_byte,
    input  logic                    i_last,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic [8*MAX_PKTLEN-1:0] o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_err
);

    localparam int            CW      = $clog2(MAX_PD_LEN + 32'd1);
    localparam int            PW      = 8 * MAX_PKTLEN;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PD_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   cnt_next_s;
    logic [PW-1:0]   build_s;
    logic [7:0]      len_s;
    logic [7:0]      chk_s;
    logic            accept_s;
    logic            seal_s;
    logic            ovf_s;

    // Place one byte at byte position pos of an otherwise zero packet vector.
    // Shifting avoids variable part-selects whose index width depends on PW.
    function automatic logic [PW-1:0] place_byte(input logic [7:0] b, input int unsigned pos);
        return PW'(b) << (pos * 32'd8);
    endfunction

`ifdef EZP_ENCODE_CHK_EN
    logic [7:0] chk_r;
    logic [7:0] chk_next_s;

    // Running XOR checksum step.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // Beats are refused while the packet is presented and while reset is held.
    assign i_ready  = !rst && (state_r != OUT);
    assign accept_s = i_valid && i_ready;

    // Next-buffer construction: first-beat init, payload store, overflow detect and sealing.
    always_comb begin
        build_s    = o_data;
        cnt_next_s = count_r;
        seal_s     = 1'b0;
        ovf_s      = 1'b0;
`ifdef EZP_ENCODE_CHK_EN
        chk_next_s = chk_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    // Clearing here guarantees every byte above the frame end is zero.
                    build_s    = place_byte(START_BYTE, 32'd0)
                               | place_byte(i_cmd, 32'd1)
                               | place_byte(i_byte, 32'd3);
                    cnt_next_s = CW'(1'b1);
                    seal_s     = i_last;
`ifdef EZP_ENCODE_CHK_EN
                    chk_next_s = chk_fold(i_cmd, i_byte);
`endif
                end else begin
                    build_s = o_data;
                end
            end
            COLLECT: begin
                if (accept_s) begin
                    if (count_r == MAX_CNT) begin
                        ovf_s = 1'b1;
                    end else begin
                        // Target byte is still zero from the first-beat clear, so OR stores it.
                        build_s    = o_data | place_byte(i_byte, 32'(count_r) + 32'd3);
                        cnt_next_s = count_r + CW'(1'b1);
                        seal_s     = i_last;
`ifdef EZP_ENCODE_CHK_EN
                        chk_next_s = chk_fold(chk_r, i_byte);
`endif
                    end
                end else begin
                    build_s = o_data;
                end
            end
            default: begin
                build_s = o_data;
            end
        endcase

        len_s = 8'(cnt_next_s);
`ifdef EZP_ENCODE_CHK_EN
        chk_s = chk_fold(chk_next_s, len_s);
`else
        chk_s = 8'h00;
`endif

        if (seal_s) begin
            build_s = build_s
                    | place_byte(len_s, 32'd2)
                    | place_byte(chk_s, 32'(cnt_next_s) + 32'd3)
                    | place_byte(END_BYTE, 32'(cnt_next_s) + 32'd4);
        end else begin
            build_s = build_s;
        end
    end

    // Packet FSM with registered buffer, valid and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_data  <= build_s;
            count_r <= cnt_next_s;
            o_err   <= ovf_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= i_last ? OUT : COLLECT;
                        o_valid <= i_last;
                    end else begin
                        state_r <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept_s && ovf_s) begin
                        state_r <= i_last ? IDLE : DROP;
                        o_valid <= 1'b0;
                    end else if (accept_s && i_last) begin
                        state_r <= OUT;
                        o_valid <= 1'b1;
                    end else begin
                        state_r <= COLLECT;
                        o_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (accept_s && i_last) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                    o_valid <= 1'b0;
                end
                OUT: begin
                    if (o_ready) begin
                        state_r <= IDLE;
                        o_valid <= 1'b0;
                    end else begin
                        state_r <= OUT;
                        o_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef EZP_ENCODE_CHK_EN
    // Checksum accumulator over CMD and stored payload bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_r <= 8'h00;
        end else begin
            chk_r <= chk_next_s;
        end
    end
`endif

endmodule

// File: tb/tb_ezp_encode.sv
// Directed testbench for ezp_encode at default parameters (7-byte packets).
module tb_ezp_encode;

    logic        clk;
    logic        rst;
    logic [7:0]  i_cmd;
    logic [7:0]  i_byte;
    logic        i_last;
    logic        i_valid;
    logic        i_ready;
    logic [55:0] o_data;
    logic        o_valid;
    logic        o_ready;
    logic        o_err;

    int total;
    int bad;

    // Expected frames, hand-computed; CHK byte depends on the build option.
`ifdef EZP_ENCODE_CHK_EN
    localparam logic [55:0] EXP_P1 = 56'h551102010210aa;
    localparam logic [55:0] EXP_P2 = 56'h00555e7f0120aa;
    localparam logic [55:0] EXP_P3 = 56'h5521b2a10230aa;
    localparam logic [55:0] EXP_P4 = 56'h005550110140aa;
`else
    localparam logic [55:0] EXP_P1 = 56'h550002010210aa;
    localparam logic [55:0] EXP_P2 = 56'h0055007f0120aa;
    localparam logic [55:0] EXP_P3 = 56'h5500b2a10230aa;
    localparam logic [55:0] EXP_P4 = 56'h005500110140aa;
`endif

    ezp_encode dut (
        .clk     (clk),
        .rst     (rst),
        .i_cmd   (i_cmd),
        .i_byte  (i_byte),
        .i_last  (i_last),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%014h expected=%014h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] b, input logic l);
        i_cmd   = c;
        i_byte  = b;
        i_last  = l;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    logic [55:0] held;

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        i_cmd   = 8'h00;
        i_byte  = 8'h00;
        i_last  = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        tick();
        tick();
        chk1("rst_o_valid", o_valid, 1'b0);
        chkv("rst_o_data", o_data, 56'h0);
        chk1("rst_o_err", o_err, 1'b0);
        chk1("rst_i_ready_low", i_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("post_rst_i_ready", i_ready, 1'b1);

        // Two-byte packet, downstream always ready.
        o_ready = 1'b1;
        send(8'h10, 8'h01, 1'b0);
        chk1("p1_mid_valid", o_valid, 1'b0);
        send(8'h10, 8'h02, 1'b1);
        chk1("p1_valid", o_valid, 1'b1);
        chkv("p1_data", o_data, EXP_P1);
        chk1("p1_out_i_ready", i_ready, 1'b0);
        tick();
        chk1("p1_valid_one_cycle", o_valid, 1'b0);
        chk1("p1_i_ready_back", i_ready, 1'b1);

        // Single-byte packet: LEN=1 and trailing zero byte.
        send(8'h20, 8'h7f, 1'b1);
        chk1("p2_valid", o_valid, 1'b1);
        chkv("p2_data", o_data, EXP_P2);
        tick();

        // Backpressure: packet held for 5 cycles while a beat is offered.
        o_ready = 1'b0;
        send(8'h30, 8'ha1, 1'b0);
        send(8'h30, 8'hb2, 1'b1);
        chk1("p3_valid", o_valid, 1'b1);
        chkv("p3_data", o_data, EXP_P3);
        held    = o_data;
        i_cmd   = 8'h40;
        i_byte  = 8'h11;
        i_last  = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk1("bp_i_ready", i_ready, 1'b0);
            tick();
            chk1("bp_valid_hold", o_valid, 1'b1);
            chkv("bp_data_stable", o_data, held);
        end
        o_ready = 1'b1;
        tick();
        chk1("bp_release_valid", o_valid, 1'b0);
        chk1("bp_release_i_ready", i_ready, 1'b1);
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk1("p4_valid", o_valid, 1'b1);
        chkv("p4_data", o_data, EXP_P4);
        tick();

        // Overflow: four beats with last only on the fourth.
        send(8'h10, 8'h01, 1'b0);
        send(8'h10, 8'h02, 1'b0);
        chk1("ovf_pre_err", o_err, 1'b0);
        send(8'h10, 8'h03, 1'b0);
        chk1("ovf_err_pulse", o_err, 1'b1);
        chk1("ovf_no_valid", o_valid, 1'b0);
        chk1("ovf_drop_i_ready", i_ready, 1'b1);
        send(8'h10, 8'h04, 1'b1);
        chk1("ovf_err_once", o_err, 1'b0);
        chk1("ovf_drop_no_valid", o_valid, 1'b0);
        tick();
        chk1("ovf_idle_no_valid", o_valid, 1'b0);
        send(8'h10, 8'h01, 1'b0);
        send(8'h10, 8'h02, 1'b1);
        chk1("after_ovf_valid", o_valid, 1'b1);
        chkv("after_ovf_data", o_data, EXP_P1);
        tick();

        // Reset while collecting.
        send(8'h10, 8'h01, 1'b0);
        rst = 1'b1;
        #1;
        chk1("rst_collect_i_ready", i_ready, 1'b0);
        tick();
        chk1("rst_collect_valid", o_valid, 1'b0);
        chkv("rst_collect_data", o_data, 56'h0);
        rst = 1'b0;

        // Reset while presenting a packet with o_ready low.
        o_ready = 1'b0;
        send(8'h10, 8'h01, 1'b0);
        send(8'h10, 8'h02, 1'b1);
        chk1("rst_out_pre_valid", o_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk1("rst_out_valid", o_valid, 1'b0);
        chkv("rst_out_data", o_data, 56'h0);
        chk1("rst_out_err", o_err, 1'b0);
        rst     = 1'b0;
        o_ready = 1'b1;
        send(8'h20, 8'h7f, 1'b1);
        chk1("clean_valid", o_valid, 1'b1);
        chkv("clean_data", o_data, EXP_P2);
        tick();
        chk1("clean_done", o_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ezp_encode.md
# ezp_encode

EZPack packet encoder that sits directly upstream of the EZPack UART transmit path. It accepts a command byte plus a streamed payload (byte-per-beat, last-flagged) and assembles a complete framed packet as a packed vector. The frame is START, CMD, LEN, payload, CHK, END. The packet is presented on a valid/ready interface whose width and byte ordering match the transmit path's packet input.

## Interface
Parameters:
- START_BYTE, 8'hAA, frame start marker (byte 0)
- END_BYTE, 8'h55, frame end marker
- MAX_PD_LEN, 2, maximum payload bytes per packet (1..255)
- MAX_PKTLEN, MAX_PD_LEN + 5, packet vector length in bytes

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_cmd  in  8  command byte, sampled on first accepted beat of a packet only
- i_byte  in  8  payload byte
- i_last  in  1  marks final payload beat
- i_valid  in  1  payload beat valid
- i_ready  out  1  encoder can accept a beat
- o_data  out  8*MAX_PKTLEN  packed packet, byte k at bits [8k+7:8k]
- o_valid  out  1  packet valid
- o_ready  in  1  downstream accepts packet
- o_err  out  1  one-cycle pulse: payload overflow, packet dropped

## Operation
- States: IDLE, COLLECT, DROP, OUT.
- A beat is accepted when i_valid && i_ready. i_ready = 1 in IDLE, COLLECT and DROP; 0 in OUT and while rst is high.
- IDLE, accepted beat:
  - clear the build buffer to all zeros;
  - byte0 = START_BYTE, byte1 = i_cmd, byte3 = i_byte;
  - count = 1.
  - If i_last, go to OUT; else go to COLLECT.
- COLLECT, accepted beat:
  - If count == MAX_PD_LEN: no store; pulse o_err; go to IDLE if i_last, else to DROP.
  - Otherwise: store i_byte at byte 3+count; count++.
  - If i_last (and no overflow), go to OUT.
- Sealing on entry to OUT:
  - byte2 = LEN = final count;
  - byte 3+LEN = CHK;
  - byte 4+LEN = END_BYTE;
  - bytes above 4+LEN are 0.
- DROP: accept and discard beats; on accepted i_last, go to IDLE. o_err is not re-pulsed.
- OUT: o_valid = 1 and o_data is held stable until o_valid && o_ready. The next cycle is IDLE.
- i_cmd on beats other than the first is ignored.
- count width is $clog2(MAX_PD_LEN+1); LEN byte is zero-extended count.
- Zero-length payloads cannot be expressed; every packet carries at least 1 payload byte.

## Timing
- Reset values: o_valid = 0, o_data = 0, o_err = 0, state = IDLE. i_ready = 1 the first cycle after rst deasserts.
- Packet assembly:
  - Last beat accepted in cycle N: o_valid = 1 in cycle N+1 with the full sealed packet.
  - Earliest handshake is cycle N+1; i_ready returns to 1 in N+2.
- Back-to-back packets:
  - One beat per cycle while collecting.
  - Peak packet rate is one packet per (LEN + 1) cycles when o_ready stays high.
- o_err:
  - Asserted in the cycle after the overflowing beat is accepted.
  - Exactly one cycle high.
- Reset mid-operation (any state, including OUT with o_valid high):
  - Next cycle: o_valid = 0, buffer = 0, state = IDLE.
  - The partial packet is lost with no o_err.

## Configuration
- EZP_ENCODE_CHK_EN defined: CHK = XOR of CMD, LEN and all payload bytes, accumulated per accepted stored beat.
- EZP_ENCODE_CHK_EN undefined:
  - CHK byte = 8'h00; no accumulator logic is present.
  - Frame layout and timing are unchanged.

## Test plan
All scenarios use defaults (MAX_PD_LEN = 2, MAX_PKTLEN = 7), macro defined unless stated.
- cmd 0x10, beats 0x01, 0x02(last), o_ready=1 -> o_data = 0x551102010210AA one cycle after last; o_valid high one cycle.
- cmd 0x20, single beat 0x7F(last) -> o_data = 0x00555E7F0120AA (LEN=1, CHK=0x5E, trailing byte 0).
- Packet 1 with o_ready=0 for 5 cycles:
  - o_valid stays 1 and o_data stays stable; i_ready = 0; offered beats are not accepted.
  - Raise o_ready: handshake completes; the next packet's first beat is accepted the following cycle.
- Beats 0x01, 0x02, 0x03, 0x04(last), no last before the 3rd:
  - o_err pulses once, the cycle after 0x03 is accepted; no o_valid.
  - Subsequent packet cmd 0x10, 0x01, 0x02(last) encodes correctly as in the first scenario.
- rst asserted in COLLECT after 1 beat, and again in OUT with o_ready=0 -> o_valid=0 and o_data=0 next cycle; a following clean packet is correct.
- Macro undefined, cmd 0x10, beats 0x01, 0x02(last) -> o_data = 0x550002010210AA.
